pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Carries an opaque DATA_W-bit bundle between two CPU pipeline stages with a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer.
- The skid buffer registers the upstream ready and breaks the combinational stall path.
- A saturating back-pressure counter supports performance observation.
- One instance is used per stage boundary (F/D, D/E, E/M, M/W), each with its own DATA_W.

Parameters:
- DATA_W, 136, width of the packed stage bundle (default = res 3 + a3 5 + instr/ao/dr/pc8 4x32).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall_cnt back-pressure counter.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held beats (replaces the old clr).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  bundle presented downstream.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on clr_n.
- Reset (clr_n=0), immediate:
  - out_valid=0, skid_valid=0, out_data=0, skid_data=0, stall_cnt=0.
  - in_ready=1 while in reset for SKID=1; for SKID=0 it follows the combinational equation (=1, since out_valid=0).
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - in_data is sampled only on Accept. out_data stays stable while out_valid & !out_ready.
- Latency: one cycle from Accept to out_valid when the stage is empty. Full throughput is 1 beat/cycle.
- SKID=1 states, encoded by {out_valid, skid_valid}:
  - EMPTY (0,0): Accept -> ONE, main <= in_data.
  - ONE (1,0), per case:
    - Accept & Emit -> ONE, main <= in_data.
    - Accept & !Emit -> FULL, skid <= in_data.
    - !Accept & Emit -> EMPTY.
    - otherwise hold.
  - FULL (1,1): in_ready=0 so Accept is impossible. Emit -> ONE, main <= skid.
  - in_ready = !skid_valid, driven directly from a flop, with no combinational path from out_ready.
- SKID=0:
  - in_ready = out_ready | !out_valid (combinational).
  - Accept loads main and sets out_valid=1.
  - Emit without Accept clears out_valid.
  - Skid registers are absent.
- flush=1 at a clock edge:
  - out_valid<=0, skid_valid<=0, out_data<=0, skid_data<=0. An all-zero instruction field is a nop downstream.
  - A beat Accepted in the same cycle is consumed and discarded.
  - flush has priority over Accept and Emit. An Emit in the flush cycle still counts as delivered downstream.
- out_data after a normal drain (Emit to EMPTY without flush) retains its last value; consumers must qualify with out_valid.
- stall_cnt:
  - Increments on every cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by clr_n.
- Reset asserted mid-operation: all state is lost immediately and no partial beat is emitted. After clr_n rises, the first accept is possible on the first edge.
- X-safety: in_data is never loaded without Accept, and out_ready is ignored when out_valid=0.

Decomposition:
- Shared package (pipe_pkg):
  - Localparams for the field widths RES_W=3, A3_W=5, WORD_W=32.
  - Derived stage-bundle widths, e.g. MW_W=136.
  - Field offsets, so instantiating stages pack and unpack consistently.
  - The 2-bit state encoding constants EMPTY/ONE/FULL.
- No sub-module is required. The skid path is inline under a generate on SKID.
- A thin wrapper, wpipe_v2, packs and unpacks the M/W fields around one pipe_stage_skid.

Test Plan:
- Reset/basic: hold clr_n=0 3 cycles, then in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5 one cycle later; stall_cnt=0.
- Back-pressure fill (SKID=1), with out_ready=0:
  - Send 0x11 then 0x22 -> in_ready drops to 0 after the second Accept.
  - A third beat, 0x33, is held upstream.
  - Raise out_ready -> order 0x11, 0x22, 0x33; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Full throughput: stream 0..99 with out_ready=1 constantly -> 100 beats in 100 consecutive cycles, in order, in_ready never 0.
- Flush: with FULL (0x11 in main, 0x22 in skid) and in_valid=1 carrying 0x44, pulse flush -> next cycle out_valid=0, out_data=0, in_ready=1; 0x44 never appears downstream.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; flush does not clear it; clr_n=0 sets 0.
- SKID=0 mode: out_valid=1, out_ready toggled each cycle -> in_ready mirrors out_ready in the same cycle; random valid/ready for 10k cycles gives in-order, lossless delivery against a scoreboard.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared field widths, M/W bundle layout and stage occupancy encoding for the
// pipeline-register stages.
package pipe_pkg;

    localparam int unsigned RES_W  = 3;
    localparam int unsigned A3_W   = 5;
    localparam int unsigned WORD_W = 32;

    // Stage bundle widths
    localparam int unsigned FD_W = 2 * WORD_W;
    localparam int unsigned MW_W = RES_W + A3_W + 4 * WORD_W;

    // M/W field offsets, LSB first: pc8, dr, ao, instr, a3, res
    localparam int unsigned MW_PC8_LSB   = 0;
    localparam int unsigned MW_DR_LSB    = MW_PC8_LSB + WORD_W;
    localparam int unsigned MW_AO_LSB    = MW_DR_LSB + WORD_W;
    localparam int unsigned MW_INSTR_LSB = MW_AO_LSB + WORD_W;
    localparam int unsigned MW_A3_LSB    = MW_INSTR_LSB + WORD_W;
    localparam int unsigned MW_RES_LSB   = MW_A3_LSB + A3_W;

    // Occupancy encoded as {out_valid, skid_valid}
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/wpipe_v2.sv
// M/W boundary register: packs the writeback fields into one bundle around a
// single pipe_stage_skid.
module wpipe_v2
    import pipe_pkg::*;
#(
    parameter int unsigned SKID = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [RES_W-1:0]  res_i,
    input  logic [A3_W-1:0]   a3_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] ao_i,
    input  logic [WORD_W-1:0] dr_i,
    input  logic [WORD_W-1:0] pc8_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [RES_W-1:0]  res_o,
    output logic [A3_W-1:0]   a3_o,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] ao_o,
    output logic [WORD_W-1:0] dr_o,
    output logic [WORD_W-1:0] pc8_o,
    output logic [15:0]       stall_cnt_o
);

    logic [MW_W-1:0] bundle_in, bundle_out;

    assign bundle_in = {res_i, a3_i, instr_i, ao_i, dr_i, pc8_i};

    pipe_stage_skid #(
        .DATA_W(MW_W),
        .SKID  (SKID),
        .CNT_W (16)
    ) u_stage (
        .clk      (clk_i),
        .clr_n    (rst_ni),
        .flush    (flush_i),
        .in_valid (valid_i),
        .in_ready (ready_o),
        .in_data  (bundle_in),
        .out_valid(valid_o),
        .out_ready(ready_i),
        .out_data (bundle_out),
        .stall_cnt(stall_cnt_o)
    );

    assign res_o   = bundle_out[MW_RES_LSB +: RES_W];
    assign a3_o    = bundle_out[MW_A3_LSB +: A3_W];
    assign instr_o = bundle_out[MW_INSTR_LSB +: WORD_W];
    assign ao_o    = bundle_out[MW_AO_LSB +: WORD_W];
    assign dr_o    = bundle_out[MW_DR_LSB +: WORD_W];
    assign pc8_o   = bundle_out[MW_PC8_LSB +: WORD_W];

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional two-entry skid buffer, synchronous
// flush and a saturating back-pressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MW_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    if (SKID != 0) begin : g_skid
        logic              main_valid_q, main_valid_d;
        logic              skid_valid_q, skid_valid_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              accept, emit;
        stage_state_e      state;

        assign state  = stage_state_e'({main_valid_q, skid_valid_q});
        // Upstream ready depends only on a flop, never on out_ready
        assign accept = in_valid & ~skid_valid_q;
        assign emit   = main_valid_q & out_ready;

        always_comb begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
            main_d       = main_q;
            skid_d       = skid_q;
            if (flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
                main_d       = '0;
                skid_d       = '0;
            end else begin
                case (state)
                    StEmpty: begin
                        if (accept) begin
                            main_valid_d = 1'b1;
                            main_d       = in_data;
                        end
                    end
                    StOne: begin
                        if (accept && emit) begin
                            main_d = in_data;
                        end else if (accept) begin
                            skid_valid_d = 1'b1;
                            skid_d       = in_data;
                        end else if (emit) begin
                            main_valid_d = 1'b0;
                        end
                    end
                    StFull: begin
                        if (emit) begin
                            main_d       = skid_q;
                            skid_valid_d = 1'b0;
                        end
                    end
                    default: skid_valid_d = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
                main_q       <= '0;
                skid_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                main_q       <= main_d;
                skid_q       <= skid_d;
            end
        end

        assign in_ready  = ~skid_valid_q;
        assign out_valid = main_valid_q;
        assign out_data  = main_q;
    end else begin : g_noskid
        logic              main_valid_q, main_valid_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic              accept, emit;

        assign in_ready = out_ready | ~main_valid_q;
        assign accept   = in_valid & in_ready;
        assign emit     = main_valid_q & out_ready;

        always_comb begin
            main_valid_d = main_valid_q;
            main_d       = main_q;
            if (flush) begin
                main_valid_d = 1'b0;
                main_d       = '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_d       = in_data;
            end else if (emit) begin
                main_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                main_valid_q <= 1'b0;
                main_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                main_q       <= main_d;
            end
        end

        assign out_valid = main_valid_q;
        assign out_data  = main_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: instance 0 is SKID=1/CNT_W=4, instance 1 is SKID=0/CNT_W=16,
// both checked every cycle against a FIFO-occupancy model.
module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic               clk   = 1'b0;
    logic               clr_n = 1'b0;
    logic [1:0]         flush;
    logic [1:0]         in_valid;
    logic [1:0]         in_ready;
    logic [1:0]         out_valid;
    logic [1:0]         out_ready;
    logic [1:0][DW-1:0] in_data;
    logic [1:0][DW-1:0] out_data;
    logic [3:0]         stall_a;
    logic [15:0]        stall_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (plain)
    int          occ  [2];
    logic [DW-1:0] ent0 [2];
    logic [DW-1:0] ent1 [2];
    logic [DW-1:0] mdat [2];
    int          mcnt [2];
    logic        macc, memt;
    logic [DW-1:0] dlog0 [$];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    logic [DW-1:0] sq [2];

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
        .clk      (clk),
        .clr_n    (clr_n),
        .flush    (flush[0]),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .in_data  (in_data[0]),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .out_data (out_data[0]),
        .stall_cnt(stall_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_plain (
        .clk      (clk),
        .clr_n    (clr_n),
        .flush    (flush[1]),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .in_data  (in_data[1]),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .out_data (out_data[1]),
        .stall_cnt(stall_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got 0x%0h, want 0x%0h", name, i, $time, act, exp);
        end
    endtask

    function automatic logic mrdy(input int i);
        if (i == 0) return occ[0] < 2;
        return (occ[1] == 0) || out_ready[1];
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 2; i++) begin
                occ[i]  = 0;
                mdat[i] = '0;
                mcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                macc = in_valid[i] && mrdy(i);
                memt = (occ[i] > 0) && out_ready[i];
                if ((occ[i] > 0) && !out_ready[i] && (mcnt[i] < cmax(i))) mcnt[i]++;
                if (memt && (i == 0)) dlog0.push_back(ent0[i]);
                if (flush[i]) begin
                    occ[i]  = 0;
                    mdat[i] = '0;
                end else begin
                    if (memt) begin
                        ent0[i] = ent1[i];
                        occ[i]--;
                    end
                    if (macc) begin
                        if (occ[i] == 0) ent0[i] = in_data[i];
                        else ent1[i] = in_data[i];
                        occ[i]++;
                    end
                    if (occ[i] > 0) mdat[i] = ent0[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 32'(in_ready[i]), 32'(mrdy(i)));
            chk("out_valid", i, 32'(out_valid[i]), 32'(occ[i] > 0));
            chk("out_data", i, 32'(out_data[i]), 32'(mdat[i]));
        end
        chk("stall_cnt", 0, 32'(stall_a), 32'(mcnt[0]));
        chk("stall_cnt", 1, 32'(stall_b), 32'(mcnt[1]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scoreboard cycle on both stages; rnd=0 drains with ready held high
    task automatic sb_cycle(input bit rnd);
        logic [1:0]    acc;
        logic [DW-1:0] want;
        int            have;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[i]   = sq[i];
            acc[i]       = in_valid[i] && mrdy(i);
            if (out_valid[i] && out_ready[i]) begin
                have = (i == 0) ? exp0.size() : exp1.size();
                if (have == 0) begin
                    chk("sb_extra_beat", i, 32'(out_data[i]), 32'hFFFF_FFFF);
                end else begin
                    want = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk("sb_data", i, 32'(out_data[i]), 32'(want));
                end
            end
            if (acc[i]) begin
                if (i == 0) exp0.push_back(sq[i]);
                else exp1.push_back(sq[i]);
                sq[i] = sq[i] + 16'd1;
            end
        end
        step();
    endtask

    initial begin
        int            base;
        logic          r;
        logic [DW-1:0] d1;
        for (int i = 0; i < 2; i++) begin
            occ[i]  = 0;
            ent0[i] = '0;
            ent1[i] = '0;
            mdat[i] = '0;
            mcnt[i] = 0;
            sq[i]   = '0;
        end
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;

        // Reset and basic one-cycle latency on both stages
        repeat (3) step();
        chk("rst_in_ready", 0, 32'(in_ready), 32'd3);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_out_data", 0, 32'(out_data[0]), 32'd0);
        chk("rst_stall", 0, 32'(stall_a), 32'd0);
        clr_n      = 1'b1;
        in_valid   = 2'b11;
        in_data[0] = 16'h00A5;
        in_data[1] = 16'h00A5;
        out_ready  = 2'b11;
        step();
        chk("basic_valid", 0, 32'(out_valid), 32'd3);
        chk("basic_data", 0, 32'(out_data[0]), 32'h00A5);
        chk("basic_data", 1, 32'(out_data[1]), 32'h00A5);
        chk("basic_stall", 0, 32'(stall_a), 32'd0);
        in_valid = '0;
        step();
        chk("drain_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("drain_retain", 0, 32'(out_data[0]), 32'h00A5);

        // Back-pressure fill of the skid stage
        out_ready   = '0;
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h0011;
        step();
        chk("fill_ready_one", 0, 32'(in_ready[0]), 32'd1);
        in_data[0] = 16'h0022;
        step();
        chk("fill_ready_full", 0, 32'(in_ready[0]), 32'd0);
        in_data[0] = 16'h0033;
        step();
        step();
        chk("fill_stall", 0, 32'(stall_a), 32'd3);
        chk("fill_head", 0, 32'(out_data[0]), 32'h0011);
        out_ready[0] = 1'b1;
        step();
        chk("unfill_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("unfill_head", 0, 32'(out_data[0]), 32'h0022);
        step();
        in_valid[0] = 1'b0;
        step();
        chk("order_count", 0, 32'(dlog0.size()), 32'd4);
        chk("order_0", 0, 32'(dlog0[1]), 32'h0011);
        chk("order_1", 0, 32'(dlog0[2]), 32'h0022);
        chk("order_2", 0, 32'(dlog0[3]), 32'h0033);
        chk("order_stall", 0, 32'(stall_a), 32'd3);

        // Flush while full with a beat waiting upstream
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0011;
        step();
        in_data[0] = 16'h0022;
        step();
        in_data[0] = 16'h0044;
        flush[0]   = 1'b1;
        step();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("flush_data", 0, 32'(out_data[0]), 32'd0);
        chk("flush_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("flush_stall", 0, 32'(stall_a), 32'd5);

        // A beat accepted in the flush cycle is discarded
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h0055;
        flush[0]    = 1'b1;
        step();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush_acc_valid", 0, 32'(out_valid[0]), 32'd0);

        // An emit in the flush cycle still counts as delivered
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0077;
        step();
        in_valid[0] = 1'b0;
        flush[0]    = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("flush_emit_count", 0, 32'(dlog0.size()), 32'd5);
        chk("flush_emit_data", 0, 32'(dlog0[4]), 32'h0077);

        // Counter saturation, flush immunity and asynchronous reset
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0066;
        step();
        in_valid[0] = 1'b0;
        repeat (20) step();
        chk("sat_stall", 0, 32'(stall_a), 32'd15);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("sat_after_flush", 0, 32'(stall_a), 32'd15);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_stall", 0, 32'(stall_a), 32'd0);
        chk("mid_rst_valid", 0, 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 0, 32'(in_ready), 32'd3);
        step();
        clr_n = 1'b1;

        // Full throughput stream 0..99 through the skid stage
        base         = dlog0.size();
        out_ready[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = DW'(k);
            chk("tput_ready", 0, 32'(in_ready[0]), 32'd1);
            step();
        end
        in_valid[0] = 1'b0;
        step();
        chk("tput_count", 0, 32'(dlog0.size() - base), 32'd100);
        for (int k = 0; k < 100; k++) begin
            chk("tput_order", 0, 32'(dlog0[base+k]), 32'(k));
        end

        // Plain stage: in_ready mirrors out_ready while holding a beat
        d1           = 16'h0100;
        in_valid[1]  = 1'b1;
        in_data[1]   = d1;
        out_ready[1] = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            r            = (k % 2) == 1;
            out_ready[1] = r;
            #1;
            chk("mirror_ready", 1, 32'(in_ready[1]), 32'(r));
            if (r) d1 = d1 + 16'd1;
            step();
            in_data[1] = d1;
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        step();

        // Random valid/ready scoreboard run on both stages
        clr_n = 1'b0;
        #1;
        clr_n = 1'b1;
        sq[0] = 16'h1000;
        sq[1] = 16'h2000;
        repeat (10000) sb_cycle(1'b1);
        repeat (4) sb_cycle(1'b0);
        chk("sb_left", 0, 32'(exp0.size()), 32'd0);
        chk("sb_left", 1, 32'(exp1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
